// File: rtl/multicycle_sequencer_if.sv
// Instruction-fetch and data-memory handshake bundle for multicycle_sequencer.
interface multicycle_sequencer_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned INST_W = 10
);
  logic              inst_req;
  logic [PC_W-1:0]   inst_addr;
  logic              inst_ack;
  logic [INST_W-1:0] inst_data;
  logic              mem_req;
  logic              mem_we;
  logic              mem_ack;

  modport master (
    output inst_req, inst_addr, mem_req, mem_we,
    input  inst_ack, inst_data, mem_ack
  );

  modport slave (
    input  inst_req, inst_addr, mem_req, mem_we,
    output inst_ack, inst_data, mem_ack
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle PC/fetch/halt sequencer with req/ack instruction and data memory handshakes.
// Define SEQ_BUS_TIMEOUT_EN to halt with bus_err when an ack fails to arrive within TIMEOUT_CYCLES.
module multicycle_sequencer #(
  parameter int unsigned     PC_W           = 16,
  parameter int unsigned     INST_W         = 10,
  parameter int unsigned     CNT_W          = 16,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  multicycle_sequencer_if.master bus,
  output logic [INST_W-1:0]     ir,
  input  logic                  dec_halt,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_reg_write,
  input  logic                  take_branch,
  input  logic [PC_W-1:0]       branch_target,
  output logic                  reg_we,
  output logic [PC_W-1:0]       pc,
  output logic                  halt,
  output logic [CNT_W-1:0]      inst_count,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [2:0]            state,
  output logic                  bus_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic   retire;
  logic   mem_to_wb;

  // A store wins over a simultaneous load, so only a pure load with register write reaches WB.
  assign mem_to_wb = dec_mem_read && dec_reg_write && !dec_mem_write;

`ifdef SEQ_BUS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;
  logic          timeout;

  assign timeout = ((state_q == S_FETCH && !bus.inst_ack) ||
                    (state_q == S_MEM   && !bus.mem_ack)) &&
                   (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_FETCH:  if (bus.inst_ack) state_d = S_DECODE;
      S_DECODE: state_d = dec_halt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        if (dec_mem_read || dec_mem_write) state_d = S_MEM;
        else if (dec_reg_write)            state_d = S_WB;
        else                               state_d = S_FETCH;
      end
      S_MEM:    if (bus.mem_ack) state_d = mem_to_wb ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
`ifdef SEQ_BUS_TIMEOUT_EN
    if (timeout) state_d = S_HALTED;
`endif
    if (start) state_d = S_FETCH;
  end

  always_comb begin
    bus.inst_req = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    reg_we       = 1'b0;
    halt         = 1'b0;
    case (state_q)
      S_FETCH:  bus.inst_req = 1'b1;
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = dec_mem_write;
      end
      S_WB:     reg_we = 1'b1;
      S_HALTED: halt   = 1'b1;
      default: ;
    endcase
  end

  // Every completed instruction returns to FETCH from EXEC, MEM or WB; that transition is the retire.
  assign retire = !start && (state_d == S_FETCH) &&
                  (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);

  assign bus.inst_addr = pc;
  assign state         = state_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc          <= RESET_PC;
      ir          <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else if (start) begin
      pc          <= RESET_PC;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      if (state_q == S_FETCH && bus.inst_ack) ir <= bus.inst_data;
      if (retire) begin
        pc <= take_branch ? branch_target : pc + 1'b1;
        if (inst_count != '1) inst_count <= inst_count + 1'b1;
      end
      if (state_q != S_IDLE && state_q != S_HALTED && cycle_count != '1)
        cycle_count <= cycle_count + 1'b1;
    end
  end

`ifdef SEQ_BUS_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else if (start) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (timeout) bus_err <= 1'b1;
    end
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; ROM acks one cycle after request,
// data memory acks after a programmable number of wait cycles.
module tb_multicycle_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  ir;
  logic        dec_halt, dec_mem_read, dec_mem_write, dec_reg_write, take_branch;
  logic [15:0] branch_target;
  logic        reg_we, halt, bus_err;
  logic [15:0] pc, inst_count, cycle_count;
  logic [2:0]  state;

  logic        start_b = 1'b0;
  logic [9:0]  ir_b;
  logic        reg_we_b, halt_b, bus_err_b;
  logic [3:0]  pc_b;
  logic [15:0] inst_count_b, cycle_count_b;
  logic [2:0]  state_b;

  logic [9:0]  rom [0:63];
  logic        rom_en = 1'b1;
  logic        rom_ack;
  int unsigned mem_delay = 0;
  int unsigned mcnt = 0;
  int unsigned n_memreq = 0, n_memwe = 0, n_regwe = 0;
  int unsigned tests = 0, fails = 0;

  multicycle_sequencer_if #(.PC_W(16), .INST_W(10)) bus ();
  multicycle_sequencer_if #(.PC_W(4),  .INST_W(10)) bus_b ();

  always #5 CLK = ~CLK;

  multicycle_sequencer #(.PC_W(16), .INST_W(10), .CNT_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .bus(bus), .ir(ir),
    .dec_halt(dec_halt), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_reg_write(dec_reg_write), .take_branch(take_branch), .branch_target(branch_target),
    .reg_we(reg_we), .pc(pc), .halt(halt), .inst_count(inst_count),
    .cycle_count(cycle_count), .state(state), .bus_err(bus_err)
  );

  multicycle_sequencer #(.PC_W(4), .INST_W(10), .CNT_W(16), .RESET_PC(4'd15), .TIMEOUT_CYCLES(15)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .start(start_b), .bus(bus_b), .ir(ir_b),
    .dec_halt(1'b0), .dec_mem_read(1'b0), .dec_mem_write(1'b0),
    .dec_reg_write(1'b0), .take_branch(1'b0), .branch_target(4'h0),
    .reg_we(reg_we_b), .pc(pc_b), .halt(halt_b), .inst_count(inst_count_b),
    .cycle_count(cycle_count_b), .state(state_b), .bus_err(bus_err_b)
  );

  // Instruction encoding decoded by the bench: [9] halt, [8] load, [7] store, [6] reg write, [5] branch.
  assign dec_halt      = ir[9];
  assign dec_mem_read  = ir[8];
  assign dec_mem_write = ir[7];
  assign dec_reg_write = ir[6];
  assign take_branch   = ir[5];
  assign branch_target = 16'h0020;

  assign bus.inst_ack  = rom_ack;
  assign bus.inst_data = rom[bus.inst_addr[5:0]];
  assign bus.mem_ack   = bus.mem_req && (mcnt >= mem_delay);

  assign bus_b.inst_ack  = bus_b.inst_req;
  assign bus_b.inst_data = '0;
  assign bus_b.mem_ack   = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rom_ack <= 1'b0;
    else        rom_ack <= rom_en && bus.inst_req && !rom_ack;
  end

  always @(posedge CLK)
    mcnt <= (bus.mem_req && !bus.mem_ack) ? mcnt + 1 : 0;

  always @(negedge CLK) begin
    if (bus.mem_req) n_memreq <= n_memreq + 1;
    if (bus.mem_we)  n_memwe  <= n_memwe + 1;
    if (reg_we)      n_regwe  <= n_regwe + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int unsigned budget);
    int unsigned n = 0;
    while (!halt && n < budget) begin
      cyc(1);
      n++;
    end
    check("halt_reached", {31'b0, halt}, 32'd1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 10'h000;
  endtask

  initial begin
    int unsigned s_memreq, s_memwe, s_regwe;
    clear_rom();
    rom[3] = 10'h200;
    cyc(3);
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_pc", {16'b0, pc}, 32'h0);
    check("rst_ir", {22'b0, ir}, 32'h0);
    check("rst_icnt", {16'b0, inst_count}, 32'd0);
    check("rst_ccnt", {16'b0, cycle_count}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    check("rst_buserr", {31'b0, bus_err}, 32'd0);
    RST_N = 1'b1;
    cyc(2);
    check("idle_wait", {29'b0, state}, 32'd0);
    check("idle_inst_req", {31'b0, bus.inst_req}, 32'd0);

    // PC wrap on the 4-bit instance
    check("b_rst_pc", {28'b0, pc_b}, 32'd15);
    start_b = 1'b1;
    cyc(1);
    start_b = 1'b0;
    cyc(2);
    check("b_exec_pc", {28'b0, pc_b}, 32'd15);
    cyc(1);
    check("b_wrap_pc", {28'b0, pc_b}, 32'd0);
    check("b_wrap_addr", {28'b0, bus_b.inst_addr}, 32'd0);
    check("b_icnt", {16'b0, inst_count_b}, 32'd1);

    // Three ALU ops then halt
    pulse_start();
    check("t1_fetch", {29'b0, state}, 32'd1);
    check("t1_inst_req", {31'b0, bus.inst_req}, 32'd1);
    cyc(14);
    check("t1_decode_halt", {29'b0, state}, 32'd2);
    check("t1_halt_low", {31'b0, halt}, 32'd0);
    check("t1_ccnt14", {16'b0, cycle_count}, 32'd14);
    cyc(1);
    check("t1_halted", {29'b0, state}, 32'd6);
    check("t1_halt", {31'b0, halt}, 32'd1);
    check("t1_icnt", {16'b0, inst_count}, 32'd3);
    check("t1_pc", {16'b0, pc}, 32'd3);
    check("t1_ccnt", {16'b0, cycle_count}, 32'd15);
    cyc(3);
    check("t1_hold_state", {29'b0, state}, 32'd6);
    check("t1_hold_ccnt", {16'b0, cycle_count}, 32'd15);
    check("t1_hold_pc", {16'b0, pc}, 32'd3);

    // Load with 3 wait cycles, ALU write, halt
    clear_rom();
    rom[0] = 10'h140;
    rom[1] = 10'h040;
    rom[2] = 10'h200;
    mem_delay = 3;
    s_memreq = n_memreq; s_memwe = n_memwe; s_regwe = n_regwe;
    pulse_start();
    check("t2_restart_pc", {16'b0, pc}, 32'd0);
    check("t2_restart_icnt", {16'b0, inst_count}, 32'd0);
    cyc(7);
    check("t2_mem_state", {29'b0, state}, 32'd4);
    check("t2_mem_we", {31'b0, bus.mem_we}, 32'd0);
    cyc(1);
    check("t2_wb_state", {29'b0, state}, 32'd5);
    check("t2_reg_we", {31'b0, reg_we}, 32'd1);
    check("t2_memreq_cycles", n_memreq - s_memreq, 32'd4);
    cyc(1);
    check("t2_retire_state", {29'b0, state}, 32'd1);
    check("t2_retire_pc", {16'b0, pc}, 32'd1);
    check("t2_retire_icnt", {16'b0, inst_count}, 32'd1);
    check("t2_regwe_pulses", n_regwe - s_regwe, 32'd1);
    wait_halt(100);
    check("t2_pc", {16'b0, pc}, 32'd2);
    check("t2_icnt", {16'b0, inst_count}, 32'd2);
    check("t2_ccnt", {16'b0, cycle_count}, 32'd17);
    check("t2_memwe_cycles", n_memwe - s_memwe, 32'd0);

    // Store at pc 5
    clear_rom();
    rom[5] = 10'h080;
    rom[6] = 10'h200;
    mem_delay = 0;
    s_regwe = n_regwe;
    pulse_start();
    cyc(24);
    check("t3_mem_state", {29'b0, state}, 32'd4);
    check("t3_mem_req", {31'b0, bus.mem_req}, 32'd1);
    check("t3_mem_we", {31'b0, bus.mem_we}, 32'd1);
    check("t3_mem_pc", {16'b0, pc}, 32'd5);
    cyc(1);
    check("t3_retire_state", {29'b0, state}, 32'd1);
    check("t3_pc", {16'b0, pc}, 32'd6);
    check("t3_mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
    wait_halt(100);
    check("t3_icnt", {16'b0, inst_count}, 32'd6);
    check("t3_ccnt", {16'b0, cycle_count}, 32'd28);
    check("t3_no_regwe", n_regwe - s_regwe, 32'd0);

    // Taken branch at pc 4
    clear_rom();
    rom[4]  = 10'h020;
    rom[32] = 10'h200;
    pulse_start();
    cyc(19);
    check("t4_exec_state", {29'b0, state}, 32'd3);
    check("t4_exec_pc", {16'b0, pc}, 32'd4);
    cyc(1);
    check("t4_target_addr", {16'b0, bus.inst_addr}, 32'h0020);
    check("t4_icnt", {16'b0, inst_count}, 32'd5);
    wait_halt(100);
    check("t4_pc", {16'b0, pc}, 32'h0020);
    check("t4_ccnt", {16'b0, cycle_count}, 32'd23);

    // start while waiting in MEM
    clear_rom();
    rom[0] = 10'h140;
    rom[1] = 10'h200;
    mem_delay = 10;
    pulse_start();
    cyc(5);
    check("t5_mem_state", {29'b0, state}, 32'd4);
    check("t5_mem_req", {31'b0, bus.mem_req}, 32'd1);
    check("t5_ccnt_pre", {16'b0, cycle_count}, 32'd5);
    pulse_start();
    check("t5_state", {29'b0, state}, 32'd1);
    check("t5_pc", {16'b0, pc}, 32'd0);
    check("t5_ccnt", {16'b0, cycle_count}, 32'd0);
    check("t5_icnt", {16'b0, inst_count}, 32'd0);
    check("t5_mem_req_drop", {31'b0, bus.mem_req}, 32'd0);
    check("t5_ir_kept", {22'b0, ir}, 32'h140);
    mem_delay = 0;
    wait_halt(100);
    check("t5_after_pc", {16'b0, pc}, 32'd1);
    check("t5_after_icnt", {16'b0, inst_count}, 32'd1);
    check("t5_after_ccnt", {16'b0, cycle_count}, 32'd9);

    // Instruction ROM never acks
    rom_en = 1'b0;
    pulse_start();
    cyc(14);
    check("t6_wait_state", {29'b0, state}, 32'd1);
    check("t6_wait_buserr", {31'b0, bus_err}, 32'd0);
    cyc(1);
`ifdef SEQ_BUS_TIMEOUT_EN
    check("t6_to_state", {29'b0, state}, 32'd6);
    check("t6_to_buserr", {31'b0, bus_err}, 32'd1);
    check("t6_to_halt", {31'b0, halt}, 32'd1);
    cyc(5);
    check("t6_sticky_buserr", {31'b0, bus_err}, 32'd1);
`else
    check("t6_no_to_state", {29'b0, state}, 32'd1);
    check("t6_no_to_buserr", {31'b0, bus_err}, 32'd0);
    check("t6_no_to_halt", {31'b0, halt}, 32'd0);
    cyc(5);
    check("t6_still_fetch", {29'b0, state}, 32'd1);
`endif
    rom_en = 1'b1;
    pulse_start();
    check("t6_restart_buserr", {31'b0, bus_err}, 32'd0);
    check("t6_restart_state", {29'b0, state}, 32'd1);

    // Asynchronous reset between clock edges
    cyc(2);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_state", {29'b0, state}, 32'd0);
    check("arst_pc", {16'b0, pc}, 32'd0);
    check("arst_ir", {22'b0, ir}, 32'h0);
    check("arst_icnt", {16'b0, inst_count}, 32'd0);
    check("arst_ccnt", {16'b0, cycle_count}, 32'd0);
    check("arst_b_pc", {28'b0, pc_b}, 32'd15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
